// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial subtraction sequencer around one full-subtractor cell
// Processes WIDTH bits LSB first, one bit per clock, with valid/ready handshakes on both sides.
module serial_sub_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             abort,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic cell_d;
   logic cell_co;

   assign cell_d  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
   assign cell_co = (~a_sr_q[0] & b_sr_q[0]) | (~a_sr_q[0] & borrow_q) | (b_sr_q[0] & borrow_q);

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         IDLE: begin
            // abort wins over acceptance in the same cycle
            if (in_valid && !abort) begin
               a_sr_d   = a;
               b_sr_d   = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               res_d    = {cell_d, res_q[WIDTH-1:1]};
               borrow_d = cell_co;
               a_sr_d   = a_sr_q >> 1;
               b_sr_d   = b_sr_q >> 1;
               if (cnt_q == LAST_BIT) begin
                  bout_d  = cell_co;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            if (abort || out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign diff      = res_q;
   assign bout      = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed and randomized bench for serial_sub_ctrl
// Expected results come from plain unsigned arithmetic on the operands.
module tb_serial_sub_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         abort = 1'b0;
   logic         busy;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] diff;
   logic         bout;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_accept = -1000;

   serial_sub_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .abort(abort), .busy(busy),
      .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .bout(bout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint model_diff(input int av, input int bv, input int bi);
      return longint'((av - bv - bi) & ((1 << W) - 1));
   endfunction

   function automatic longint model_bout(input int av, input int bv, input int bi);
      return (av < bv + bi) ? 1 : 0;
   endfunction

   // Offer operands, wait for the result, hold it for `stall` cycles, then release.
   task automatic do_op(input int av, input int bv, input int bi, input int stall,
                        input bit spacing_chk, input string tag);
      int n;
      int busy_cnt;
      logic [W-1:0] held_diff;
      logic held_bout;
      bit stable;
      bit refused;
      chk({tag, "_in_ready_idle"}, in_ready, 1);
      a = av[W-1:0]; b = bv[W-1:0]; bin = bi[0]; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (spacing_chk) chk({tag, "_spacing_ok"}, (cyc - last_accept) >= W + 2, 1);
      last_accept = cyc;
      in_valid = 1'b0;
      a = $urandom; b = $urandom; bin = $urandom;
      n = 0; busy_cnt = 0;
      while (!out_valid && n < 40) begin
         if (busy) busy_cnt++;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, n, W);
      chk({tag, "_busy_cycles"}, busy_cnt, W);
      chk({tag, "_diff"}, diff, model_diff(av, bv, bi));
      chk({tag, "_bout"}, bout, model_bout(av, bv, bi));
      held_diff = diff; held_bout = bout;
      stable = 1'b1; refused = 1'b1;
      for (int s = 0; s < stall; s++) begin
         in_valid = 1'b1; a = $urandom; b = $urandom; bin = $urandom;
         if (in_ready) refused = 1'b0;
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || diff !== held_diff || bout !== held_bout) stable = 1'b0;
      end
      in_valid = 1'b0;
      if (stall > 0) begin
         chk({tag, "_stall_stable"}, stable, 1);
         chk({tag, "_stall_refused"}, refused, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_released"}, {out_valid, in_ready}, 2'b01);
      chk({tag, "_diff_kept"}, diff, held_diff);
   endtask

   initial begin
      int av, bv, bi, st;
      bit quiet;
      #2;
      chk("reset_outputs", {in_ready, busy, out_valid, bout}, 4'b1000);
      chk("reset_diff", diff, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'h05, 8'h03, 0, 0, 0, "t1");
      do_op(8'h03, 8'h05, 0, 0, 0, "t2a");
      do_op(8'h00, 8'h00, 1, 0, 0, "t2b");
      do_op(8'hFF, 8'hFF, 1, 0, 0, "t2c");
      do_op(8'h80, 8'h01, 0, 0, 0, "t2d");
      do_op(8'hA5, 8'h5A, 0, 5, 0, "t3");

      // abort sampled on the 4th edge after acceptance
      a = 8'h10; b = 8'h01; bin = 0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      chk("abort_still_busy", busy, 1);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      chk("abort_to_idle", {in_ready, busy, out_valid}, 3'b100);
      quiet = 1'b1;
      repeat (12) begin @(posedge clk); @(negedge clk); if (out_valid) quiet = 1'b0; end
      chk("abort_no_result", quiet, 1);
      out_ready = 1'b0;
      do_op(8'h09, 8'h04, 0, 0, 0, "t4");

      // abort in IDLE blocks acceptance
      in_valid = 1'b1; abort = 1'b1; a = 8'h33; b = 8'h11;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      chk("abort_idle_no_accept", {in_ready, busy}, 2'b10);

      // asynchronous reset between edges during RUN
      a = 8'h77; b = 8'h22; bin = 0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outputs", {in_ready, busy, out_valid, bout}, 4'b1000);
      chk("async_rst_diff", diff, 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (12) begin @(posedge clk); @(negedge clk); if (out_valid) quiet = 1'b0; end
      chk("async_rst_no_result", quiet, 1);
      do_op(8'hC8, 8'h3D, 1, 0, 0, "t5");

      for (int i = 0; i < 200; i++) begin
         av = $urandom_range(0, (1 << W) - 1);
         bv = $urandom_range(0, (1 << W) - 1);
         bi = $urandom_range(0, 1);
         st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         do_op(av, bv, bi, st, i > 0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL global_timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
